run_ctrl: RTL and testbench
===========================

// Module: run_ctrl
// PURPOSE
//  Top-level run sequencer for the single-cycle core. Takes the 4-phase req/done
//  handshake from the testbench, resets the core (PC, flags), runs it until the
//  decoder raises Halt or a cycle watchdog expires, then reports done. Also arbitrates
//  the dat_mem write port: testbench owns it while idle/done, core owns it while running.
// PARAMETERS
//  CW       16        width of cycle counter
//  MAX_CYC  16'hFFFF  watchdog limit, RUN cycles before forced stop (1..2^CW-1)
//  RST_CYC  2         cycles core_rst is held after req accepted (>=1)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   synchronous, active-high
//  req          in   1   start request (level, 4-phase)
//  halt         in   1   Halt from Control decoder
//  core_rst     out  1   reset to PC / flag registers
//  core_en      out  1   core clock-enable; high only in RUN
//  done         out  1   run complete
//  busy         out  1   high in RST or RUN
//  timeout      out  1   last run ended by watchdog
//  cycles       out  CW  RUN cycles of current/last run
//  ext_wr_en    in   1   testbench mem write enable
//  ext_addr     in   8   testbench mem address
//  ext_dat      in   8   testbench mem write data
//  core_wr_en   in   1   core MemWrite
//  core_addr    in   8   core address (datA)
//  core_dat     in   8   core write data (datB)
//  mem_wr_en    out  1   to dat_mem wr_en
//  mem_addr     out  8   to dat_mem addr
//  mem_dat      out  8   to dat_mem dat_in
//  ext_err      out  1   sticky: ext write attempted while busy (dropped)
// BEHAVIOUR
//  States IDLE, RST, RUN, DONE (registered). reset -> IDLE, rst_cnt=0, cycles=0,
//   timeout=0, ext_err=0; hence core_rst=1, core_en=0, done=0, busy=0 on reset.
//  IDLE: core_rst=1. req=1 -> RST, rst_cnt=0, cycles=0, timeout=0.
//  RST: core_rst=1, busy=1. rst_cnt++ each cycle; rst_cnt==RST_CYC-1 -> RUN.
//   halt ignored in RST.
//  RUN: core_rst=0, core_en=1, busy=1. cycles++ each RUN cycle (incl. halting cycle).
//   halt=1 -> DONE, timeout=0. Else cycles==MAX_CYC-1 -> DONE, timeout=1.
//   halt and watchdog same cycle: halt wins, timeout=0.
//  DONE: done=1, core_en=0, core_rst=0 (state frozen for readback); cycles, timeout
//   held. req=0 -> IDLE (done falls next cycle). req held high stays in DONE.
//  req dropping during RST/RUN is ignored; run completes, DONE exits immediately.
//  done/busy/core_rst/core_en are decoded from registered state only (glitch-free).
//  Mem mux (combinational): IDLE/DONE -> ext_* drive mem_*; RUN -> core_* drive mem_*;
//   RST -> addr/dat from core, mem_wr_en forced 0.
//  ext_wr_en=1 in RST/RUN: write dropped, ext_err<=1 until reset.
//  cycles never wraps: DONE reached at most at cycles==MAX_CYC.
//  reset in any state: immediate return to IDLE next edge, in-flight run abandoned.
// TESTING
//  1 reset, req=1, halt at 5th RUN cycle -> core_rst 1 for 2 cycles after accept,
//    done=1 cycle after halt, cycles=5, timeout=0; req=0 -> done=0 next cycle.
//  2 MAX_CYC=8, halt never -> DONE after 8 RUN cycles, cycles=8, timeout=1.
//  3 halt asserted on watchdog cycle (MAX_CYC=8) -> cycles=8, timeout=0.
//  4 ext write addr 0x10 data 0xA5 in IDLE -> mem_wr_en=1; same during RUN ->
//    mem_wr_en follows core_wr_en only, ext_err=1 and stays 1.
//  5 reset asserted mid-RUN (cycle 3) -> IDLE, core_rst=1, cycles=0, done=0;
//    new req runs normally.
//  6 req held high after done -> stays DONE, no restart; halt during RST ignored.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer for the single-cycle core.
// Sequences core reset/run/halt and arbitrates the data-memory write port.
module run_ctrl #(
    parameter int            CW      = 16,
    parameter logic [CW-1:0] MAX_CYC = CW'(16'hFFFF),
    parameter int            RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          halt,
    output logic          core_rst,
    output logic          core_en,
    output logic          done,
    output logic          busy,
    output logic          timeout,
    output logic [CW-1:0] cycles,
    input  logic          ext_wr_en,
    input  logic [7:0]    ext_addr,
    input  logic [7:0]    ext_dat,
    input  logic          core_wr_en,
    input  logic [7:0]    core_addr,
    input  logic [7:0]    core_dat,
    output logic          mem_wr_en,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_dat,
    output logic          ext_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RST  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
    localparam logic [CW-1:0] CYC_LAST = MAX_CYC - CW'(1);

    logic [1:0]    state;
    logic [RW-1:0] rst_cnt;

    // Status outputs come straight from the state register so they never glitch.
    assign core_rst = (state == IDLE) || (state == RST);
    assign core_en  = (state == RUN);
    assign done     = (state == DONE);
    assign busy     = (state == RST) || (state == RUN);

    // Run sequencer: reset hold, run with watchdog, then wait for req to drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rst_cnt <= '0;
            cycles  <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= RST;
                        rst_cnt <= '0;
                        cycles  <= '0;
                        timeout <= 1'b0;
                    end
                end
                RST: begin
                    rst_cnt <= rst_cnt + RW'(1);
                    if (rst_cnt == RST_LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The halting/expiring cycle is counted, so cycles
                    // tops out at MAX_CYC and can never wrap.
                    cycles <= cycles + CW'(1);
                    if (halt) begin
                        state   <= DONE;
                        timeout <= 1'b0;
                    end else if (cycles == CYC_LAST) begin
                        state   <= DONE;
                        timeout <= 1'b1;
                    end
                end
                DONE: begin
                    if (!req) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky flag for testbench writes dropped while the core owns memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_err <= 1'b0;
        end else if (ext_wr_en && busy) begin
            ext_err <= 1'b1;
        end
    end

    // Memory port mux: testbench when idle/done, core otherwise.
    always_comb begin
        mem_wr_en = ext_wr_en;
        mem_addr  = ext_addr;
        mem_dat   = ext_dat;
        case (state)
            RUN: begin
                mem_wr_en = core_wr_en;
                mem_addr  = core_addr;
                mem_dat   = core_dat;
            end
            RST: begin
                // Core is still being reset; its MemWrite is not trusted yet.
                mem_wr_en = 1'b0;
                mem_addr  = core_addr;
                mem_dat   = core_dat;
            end
            default: begin
                mem_wr_en = ext_wr_en;
                mem_addr  = ext_addr;
                mem_dat   = ext_dat;
            end
        endcase
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: self-checking bench for run_ctrl.
// Directed scenarios plus randomized runs against a run-length model.
module tb_run_ctrl;

    localparam int CW   = 16;
    localparam int MAXC = 8;
    localparam int RSTC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          halt = 1'b0;
    logic          core_rst, core_en, done, busy, timeout;
    logic [CW-1:0] cycles;
    logic          ext_wr_en = 1'b0;
    logic [7:0]    ext_addr = 8'h00;
    logic [7:0]    ext_dat = 8'h00;
    logic          core_wr_en = 1'b0;
    logic [7:0]    core_addr = 8'h00;
    logic [7:0]    core_dat = 8'h00;
    logic          mem_wr_en;
    logic [7:0]    mem_addr, mem_dat;
    logic          ext_err;

    int vecs = 0;
    int errs = 0;

    run_ctrl #(
        .CW(CW),
        .MAX_CYC(CW'(MAXC)),
        .RST_CYC(RSTC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .halt(halt),
        .core_rst(core_rst), .core_en(core_en), .done(done),
        .busy(busy), .timeout(timeout), .cycles(cycles),
        .ext_wr_en(ext_wr_en), .ext_addr(ext_addr), .ext_dat(ext_dat),
        .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_dat(core_dat), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_dat(mem_dat), .ext_err(ext_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: a run halted on RUN cycle h (1-based, 0 = never) lasts
    // h cycles if h fits under the watchdog, otherwise exactly MAXC.
    function automatic int exp_cyc(input int h);
        return (h >= 1 && h <= MAXC) ? h : MAXC;
    endfunction

    function automatic logic exp_to(input int h);
        return (h >= 1 && h <= MAXC) ? 1'b0 : 1'b1;
    endfunction

    // Stimulus only: accept, sit through reset hold, run until the
    // model says the run should be over.
    task automatic drive_run(input int h);
        req = 1'b1;
        tick;
        for (int i = 0; i < RSTC; i++) tick;
        for (int k = 1; k <= exp_cyc(h); k++) begin
            halt = (k == h);
            tick;
        end
        halt = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        vecs++;
        if ({core_rst, core_en, done, busy} !== 4'b1000) begin
            errs++;
            $display("FAIL reset_ctl: rst/en/done/busy=%b want 1000",
                     {core_rst, core_en, done, busy});
        end
        vecs++;
        if (cycles !== '0 || timeout !== 1'b0 || ext_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_regs: cyc=%0d to=%b err=%b want 0 0 0",
                     cycles, timeout, ext_err);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        req = 1'b1;
        tick;
        for (int i = 0; i < RSTC; i++) begin
            vecs++;
            if (core_rst !== 1'b1 || busy !== 1'b1 || core_en !== 1'b0) begin
                errs++;
                $display("FAIL basic_rst%0d: rst=%b busy=%b en=%b want 1 1 0",
                         i, core_rst, busy, core_en);
            end
            tick;
        end
        for (int k = 1; k <= 5; k++) begin
            vecs++;
            if (core_en !== 1'b1 || core_rst !== 1'b0 || done !== 1'b0) begin
                errs++;
                $display("FAIL basic_run%0d: en=%b rst=%b done=%b want 1 0 0",
                         k, core_en, core_rst, done);
            end
            halt = (k == 5);
            tick;
        end
        halt = 1'b0;
        vecs++;
        if (done !== 1'b1 || cycles !== CW'(5) || timeout !== 1'b0) begin
            errs++;
            $display("FAIL basic_done: done=%b cyc=%0d to=%b want 1 5 0",
                     done, cycles, timeout);
        end
        vecs++;
        if ({core_rst, core_en, busy} !== 3'b000) begin
            errs++;
            $display("FAIL basic_done_ctl: rst/en/busy=%b want 000",
                     {core_rst, core_en, busy});
        end
        req = 1'b0;
        tick;
        vecs++;
        if (done !== 1'b0 || core_rst !== 1'b1 || cycles !== CW'(5)) begin
            errs++;
            $display("FAIL basic_idle: done=%b rst=%b cyc=%0d want 0 1 5",
                     done, core_rst, cycles);
        end
    endtask

    task automatic test_watchdog;
        drive_run(0);
        vecs++;
        if (done !== 1'b1 || cycles !== CW'(MAXC) || timeout !== 1'b1) begin
            errs++;
            $display("FAIL wd: done=%b cyc=%0d to=%b want 1 %0d 1",
                     done, cycles, timeout, MAXC);
        end
        req = 1'b0;
        tick;
        drive_run(MAXC);
        vecs++;
        if (done !== 1'b1 || cycles !== CW'(MAXC) || timeout !== 1'b0) begin
            errs++;
            $display("FAIL wd_halt: done=%b cyc=%0d to=%b want 1 %0d 0",
                     done, cycles, timeout, MAXC);
        end
        req = 1'b0;
        tick;
    endtask

    task automatic test_mem;
        ext_wr_en = 1'b1;
        ext_addr  = 8'h10;
        ext_dat   = 8'hA5;
        core_wr_en = 1'b0;
        core_addr = 8'h33;
        core_dat  = 8'h5C;
        #1;
        vecs++;
        if ({mem_wr_en, mem_addr, mem_dat} !== {1'b1, 8'h10, 8'hA5}) begin
            errs++;
            $display("FAIL mem_idle: we=%b a=%h d=%h want 1 10 a5",
                     mem_wr_en, mem_addr, mem_dat);
        end
        tick;
        vecs++;
        if (ext_err !== 1'b0) begin
            errs++;
            $display("FAIL mem_idle_err: err=%b want 0", ext_err);
        end
        ext_wr_en = 1'b0;
        req = 1'b1;
        tick;
        core_wr_en = 1'b1;
        #1;
        vecs++;
        if ({mem_wr_en, mem_addr, mem_dat} !== {1'b0, 8'h33, 8'h5C}) begin
            errs++;
            $display("FAIL mem_rst: we=%b a=%h d=%h want 0 33 5c",
                     mem_wr_en, mem_addr, mem_dat);
        end
        for (int i = 0; i < RSTC; i++) tick;
        ext_wr_en = 1'b1;
        core_wr_en = 1'b0;
        #1;
        vecs++;
        if ({mem_wr_en, mem_addr, mem_dat} !== {1'b0, 8'h33, 8'h5C}) begin
            errs++;
            $display("FAIL mem_run0: we=%b a=%h d=%h want 0 33 5c",
                     mem_wr_en, mem_addr, mem_dat);
        end
        core_wr_en = 1'b1;
        #1;
        vecs++;
        if (mem_wr_en !== 1'b1) begin
            errs++;
            $display("FAIL mem_run1: we=%b want 1", mem_wr_en);
        end
        halt = 1'b1;
        tick;
        halt = 1'b0;
        ext_wr_en = 1'b0;
        core_wr_en = 1'b0;
        vecs++;
        if (ext_err !== 1'b1 || done !== 1'b1 || cycles !== CW'(1)) begin
            errs++;
            $display("FAIL mem_err: err=%b done=%b cyc=%0d want 1 1 1",
                     ext_err, done, cycles);
        end
        ext_wr_en = 1'b1;
        #1;
        vecs++;
        if ({mem_wr_en, mem_addr} !== {1'b1, 8'h10}) begin
            errs++;
            $display("FAIL mem_done: we=%b a=%h want 1 10",
                     mem_wr_en, mem_addr);
        end
        ext_wr_en = 1'b0;
        req = 1'b0;
        tick;
        tick;
        vecs++;
        if (ext_err !== 1'b1) begin
            errs++;
            $display("FAIL mem_sticky: err=%b want 1", ext_err);
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vecs++;
        if (ext_err !== 1'b0) begin
            errs++;
            $display("FAIL mem_clear: err=%b want 0", ext_err);
        end
    endtask

    task automatic test_reset_mid_run;
        req = 1'b1;
        tick;
        for (int i = 0; i < RSTC + 2; i++) tick;
        reset = 1'b1;
        req = 1'b0;
        tick;
        reset = 1'b0;
        vecs++;
        if ({core_rst, core_en, done, busy} !== 4'b1000 || cycles !== '0) begin
            errs++;
            $display("FAIL mid_reset: rst/en/done/busy=%b cyc=%0d want 1000 0",
                     {core_rst, core_en, done, busy}, cycles);
        end
        drive_run(4);
        vecs++;
        if (done !== 1'b1 || cycles !== CW'(4) || timeout !== 1'b0) begin
            errs++;
            $display("FAIL mid_rerun: done=%b cyc=%0d to=%b want 1 4 0",
                     done, cycles, timeout);
        end
        req = 1'b0;
        tick;
    endtask

    task automatic test_hold;
        req = 1'b1;
        tick;
        halt = 1'b1;
        for (int i = 0; i < RSTC; i++) tick;
        halt = 1'b0;
        vecs++;
        if (core_en !== 1'b1 || done !== 1'b0 || cycles !== '0) begin
            errs++;
            $display("FAIL hold_rst_halt: en=%b done=%b cyc=%0d want 1 0 0",
                     core_en, done, cycles);
        end
        for (int k = 1; k <= 3; k++) begin
            halt = (k == 3);
            tick;
        end
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (done !== 1'b1 || busy !== 1'b0 || cycles !== CW'(3)) begin
                errs++;
                $display("FAIL hold_done%0d: done=%b busy=%b cyc=%0d want 1 0 3",
                         i, done, busy, cycles);
            end
            tick;
        end
        req = 1'b0;
        tick;
        vecs++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL hold_exit: done=%b want 0", done);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 25; n++) begin
            int h;
            h = $urandom_range(0, MAXC + 3);
            ext_wr_en = 1'($urandom_range(0, 1));
            ext_addr  = 8'($urandom);
            ext_dat   = 8'($urandom);
            core_wr_en = 1'($urandom_range(0, 1));
            core_addr = 8'($urandom);
            core_dat  = 8'($urandom);
            #1;
            vecs++;
            if ({mem_wr_en, mem_addr, mem_dat}
                !== {ext_wr_en, ext_addr, ext_dat}) begin
                errs++;
                $display("FAIL rnd_idle_mux%0d: got %b/%h/%h want %b/%h/%h",
                         n, mem_wr_en, mem_addr, mem_dat,
                         ext_wr_en, ext_addr, ext_dat);
            end
            ext_wr_en = 1'b0;
            req = 1'b1;
            tick;
            for (int i = 0; i < RSTC; i++) tick;
            for (int k = 1; k <= exp_cyc(h); k++) begin
                core_wr_en = 1'($urandom_range(0, 1));
                core_addr = 8'($urandom);
                core_dat  = 8'($urandom);
                halt = (k == h);
                #1;
                vecs++;
                if (core_en !== 1'b1 || cycles !== CW'(k - 1)
                    || {mem_wr_en, mem_addr, mem_dat}
                       !== {core_wr_en, core_addr, core_dat}) begin
                    errs++;
                    $display("FAIL rnd_run%0d.%0d: en=%b cyc=%0d mux=%b/%h/%h",
                             n, k, core_en, cycles,
                             mem_wr_en, mem_addr, mem_dat);
                end
                tick;
            end
            halt = 1'b0;
            vecs++;
            if (done !== 1'b1 || cycles !== CW'(exp_cyc(h))
                || timeout !== exp_to(h)) begin
                errs++;
                $display("FAIL rnd_end%0d: done=%b cyc=%0d to=%b want 1 %0d %b",
                         n, done, cycles, timeout, exp_cyc(h), exp_to(h));
            end
            req = 1'b0;
            tick;
        end
        vecs++;
        if (ext_err !== 1'b0) begin
            errs++;
            $display("FAIL rnd_err: err=%b want 0", ext_err);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_watchdog;
        test_mem;
        test_reset_mid_run;
        test_hold;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
